// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Two-port arbiter/sequencer in front of a single combinational-read memory.
// Port 0 (CPU) and port 1 (loader/DMA) raise req and hold their operation
// until a one-cycle ack. One access is in flight at a time. Grants alternate
// round-robin under contention. Reads hold mem_read for READ_WAIT cycles
// (legal 1..15) so the memory's read delay settles before data is captured.
//
// Ports
//   clk, reset          : rising-edge clock, asynchronous active-low reset
//   m0_req/we/addr/wdata: port 0 request (we=1 write, 0 read)
//   m0_rdata, m0_ack    : port 0 registered read data and completion pulse
//   m1_*                : same for port 1
//   mem_read, mem_write : memory strobes, high only while an access is busy
//   mem_addr            : address to memory (0 outside an access)
//   mem_write_data      : write data to memory (0 outside an access)
//   mem_read_data       : combinational read data from memory
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int READ_WAIT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_ack,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_ack,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    // A read spends READ_WAIT cycles in BUSY: the counter runs READ_WAIT-1..0.
    localparam logic [3:0] READ_CNT_INIT = 4'(READ_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic        gnt_reg, gnt_next;
    logic        last_reg, last_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic        pick;

    // Port bundles gathered into vectors so the granted port can be muxed.
    logic [1:0]  req_v;
    logic [1:0]  we_v;
    logic [1:0]  ack_v;
    logic [31:0] addr_v  [2];
    logic [31:0] wdata_v [2];

    logic        busy;
    logic        we_g;
    logic        capture;

    assign req_v      = {m1_req, m0_req};
    assign we_v       = {m1_we, m0_we};
    assign addr_v[0]  = m0_addr;
    assign addr_v[1]  = m1_addr;
    assign wdata_v[0] = m0_wdata;
    assign wdata_v[1] = m1_wdata;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            gnt_reg   <= 1'b0;
            last_reg  <= 1'b1;  // port 0 wins the first contention
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            gnt_reg   <= gnt_next;
            last_reg  <= last_next;
            cnt_reg   <= cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        gnt_next   = gnt_reg;
        last_next  = last_reg;
        cnt_next   = cnt_reg;
        // Single requester wins outright; on contention the port not served
        // last time goes next.
        pick       = (req_v == 2'b11) ? ~last_reg : req_v[1];

        case (state_reg)
            IDLE: begin
                if (req_v != 2'b00) begin
                    gnt_next   = pick;
                    last_next  = pick;
                    state_next = BUSY;
                    cnt_next   = we_v[pick] ? 4'd0 : READ_CNT_INIT;
                end
            end
            BUSY: begin
                if (cnt_reg != 4'd0) begin
                    cnt_next = cnt_reg - 4'd1;
                end else begin
                    state_next = ACK;
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Memory-side outputs, decoded from registered state. Requesters hold
    // their inputs stable through the access, so the mux is steady too.
    // ------------------------------------------------------------------
    assign busy           = (state_reg == BUSY);
    assign we_g           = we_v[gnt_reg];
    assign capture        = busy && (cnt_reg == 4'd0) && !we_g;
    assign mem_read       = busy && !we_g;
    assign mem_write      = busy && we_g;
    assign mem_addr       = busy ? addr_v[gnt_reg]  : 32'd0;
    assign mem_write_data = busy ? wdata_v[gnt_reg] : 32'd0;

    // ------------------------------------------------------------------
    // Per-port read-data holding register and ack decode.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            logic [31:0] rdata_reg;

            assign ack_v[gi] = (state_reg == ACK) && (gnt_reg == 1'(gi));

            // Only a completing read on this port updates its data.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    rdata_reg <= 32'd0;
                end else if (capture && (gnt_reg == 1'(gi))) begin
                    rdata_reg <= mem_read_data;
                end
            end
        end
    endgenerate

    assign m0_rdata = g_port[0].rdata_reg;
    assign m1_rdata = g_port[1].rdata_reg;
    assign m0_ack   = ack_v[0];
    assign m1_ack   = ack_v[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Bench for mem_arbiter with READ_WAIT=3 and a 256-word memory behind it.
// Directed single transactions come from a vector table; reset-in-flight,
// contention ordering and back-to-back reads are hand sequences; a random
// phase drives both ports and compares against a transaction-level model.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int RW = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m0_ack;
    logic        m1_req, m1_we;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        m1_ack;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_write_data, mem_read_data;

    always #5 clk = ~clk;

    mem_arbiter #(.READ_WAIT(RW)) dut (
        .clk            (clk),
        .reset          (reset),
        .m0_req         (m0_req),
        .m0_we          (m0_we),
        .m0_addr        (m0_addr),
        .m0_wdata       (m0_wdata),
        .m0_rdata       (m0_rdata),
        .m0_ack         (m0_ack),
        .m1_req         (m1_req),
        .m1_we          (m1_we),
        .m1_addr        (m1_addr),
        .m1_wdata       (m1_wdata),
        .m1_rdata       (m1_rdata),
        .m1_ack         (m1_ack),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    // ------------------------------------------------------------------
    // Memory: combinational read, commit on the rising edge.
    // ------------------------------------------------------------------
    logic [31:0] mem [256];
    bit          mem_ready = 1'b0;

    function automatic logic [31:0] init_word(input int idx);
        return 32'h1000_0000 + 32'(idx) * 32'h0001_0003;
    endfunction

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
            mem[5]    <= 32'hDEAD_BEEF;
            mem_ready <= 1'b1;
        end else if (mem_write) begin
            mem[mem_addr[9:2]] <= mem_write_data;
        end
    end

    assign mem_read_data = mem[mem_addr[9:2]];

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int p, input bit req, input bit we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (p == 0) begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end else begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end
    endtask

    task automatic do_reset();
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // One isolated transaction, started and returning at a falling edge.
    task automatic do_txn(input int p, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, output int edges,
                          output int nrd, output int nwr, output int own,
                          output int other, output bit done);
        edges = 0; nrd = 0; nwr = 0; own = 0; other = 0; done = 1'b0;
        drive(p, 1'b1, we, addr, wdata);
        for (int c = 0; c < 40 && !done; c++) begin
            @(posedge clk); @(negedge clk);
            edges++;
            nrd   += int'(mem_read);
            nwr   += int'(mem_write);
            own   += int'(p == 0 ? m0_ack : m1_ack);
            other += int'(p == 0 ? m1_ack : m0_ack);
            if ((p == 0 ? m0_ack : m1_ack) == 1'b1) done = 1'b1;
        end
        // Inputs stay put until the ACK cycle is over.
        @(posedge clk); @(negedge clk);
        nrd   += int'(mem_read);
        nwr   += int'(mem_write);
        own   += int'(p == 0 ? m0_ack : m1_ack);
        other += int'(p == 0 ? m1_ack : m0_ack);
        drive(p, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk); @(negedge clk);
    endtask

    function automatic logic [95:0] status();
        return {28'd0, mem_read, mem_write, m0_ack, m1_ack, mem_addr, mem_write_data};
    endfunction

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        int          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_edges;
    } vec_t;

    vec_t        tbl [7];
    logic [31:0] exp_rd [2];

    // Random-phase model and agent state
    logic [31:0] ref_mem [256];
    bit          a_valid, a_we, mlast, pick, ackp;
    int          a_port, a_start, a_lat, free_edge, e, n_racks;
    logic [31:0] a_addr, a_wdata;
    bit          agent_busy [2];
    bit          acked [2];
    logic [95:0] exp_stat;

    // Scratch
    int          edges, nrd, nwr, own, other, nacks, cyc, overlap;
    bit          done;
    int          ack_at [3];
    int          order [$];
    int          cidx [2];
    bit          change [2];
    int          p_ack;

    task automatic new_op(input int p);
        bit          we;
        logic [31:0] a;
        we = 1'($urandom_range(0, 1));
        a  = 32'($urandom_range(0, 15)) << 2;
        drive(p, 1'b1, we, a, $urandom);
        agent_busy[p] = 1'b1;
    endtask

    initial begin
        tbl[0] = '{0, 1'b0, 32'h14, 32'h0,         32'hDEAD_BEEF, RW + 1};
        tbl[1] = '{1, 1'b1, 32'h08, 32'h1234_5678, 32'h0,         2};
        tbl[2] = '{0, 1'b1, 32'h40, 32'hCAFE_F00D, 32'h0,         2};
        tbl[3] = '{0, 1'b0, 32'h40, 32'h0,         32'hCAFE_F00D, RW + 1};
        tbl[4] = '{1, 1'b0, 32'h08, 32'h0,         32'h1234_5678, RW + 1};
        tbl[5] = '{1, 1'b0, 32'h14, 32'h0,         32'hDEAD_BEEF, RW + 1};
        tbl[6] = '{0, 1'b1, 32'h3FC, 32'hFFFF_0001, 32'h0,        2};

        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state, checked while reset is still low
        check("reset_outputs", status(), 96'd0);
        check("reset_rdata", {m0_rdata, m1_rdata}, 64'd0);
        reset = 1'b1;
        @(negedge clk);
        exp_rd[0] = 32'd0;
        exp_rd[1] = 32'd0;

        // ---------------- Table-driven single transactions ----------------
        for (int i = 0; i < 7; i++) begin
            do_txn(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata,
                   edges, nrd, nwr, own, other, done);
            check($sformatf("v%0d_ack_seen", i), 96'(done), 96'd1);
            check($sformatf("v%0d_edges", i), 96'(edges), 96'(tbl[i].exp_edges));
            check($sformatf("v%0d_strobes", i), {32'(nrd), 32'(nwr)},
                  tbl[i].we ? {32'd0, 32'd1} : {32'(RW), 32'd0});
            check($sformatf("v%0d_acks", i), {32'(own), 32'(other)}, {32'd1, 32'd0});
            if (!tbl[i].we) exp_rd[tbl[i].port] = tbl[i].exp_rdata;
            check($sformatf("v%0d_rdata", i), {m0_rdata, m1_rdata}, {exp_rd[0], exp_rd[1]});
            if (tbl[i].we)
                check($sformatf("v%0d_mem", i), mem[tbl[i].addr[9:2]], tbl[i].wdata);
            $display("vec %0d: port %0d we %0d addr %h edges %0d rd %0d wr %0d", i,
                     tbl[i].port, tbl[i].we, tbl[i].addr, edges, nrd, nwr);
        end

        // ---------------- Reset during the second BUSY cycle of a read ----
        drive(0, 1'b1, 1'b0, 32'h14, 32'd0);
        @(posedge clk);              // request sampled
        @(posedge clk);              // second BUSY cycle begins
        #2;
        check("midbusy_read_high", 96'(mem_read), 96'd1);
        reset = 1'b0;
        #1;
        check("async_drop", status(), 96'd0);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        own = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); @(negedge clk);
            own += int'(m0_ack) + int'(m1_ack);
        end
        check("midbusy_no_ack", 96'(own), 96'd0);
        check("midbusy_rdata", {m0_rdata, m1_rdata}, 64'd0);
        do_txn(0, 1'b0, 32'h14, 32'd0, edges, nrd, nwr, own, other, done);
        check("after_reset_txn", {32'(edges), 32'(own), m0_rdata}, {32'(RW + 1), 32'd1, 32'hDEAD_BEEF});
        $display("reset mid-busy: recovery read edges %0d rdata %h", edges, m0_rdata);

        // ---------------- Continuous contention ---------------------------
        do_reset();
        cidx[0] = 0; cidx[1] = 0; change[0] = 0; change[1] = 0; overlap = 0;
        order.delete();
        drive(0, 1'b1, 1'b0, 32'h100, 32'd0);
        drive(1, 1'b1, 1'b0, 32'h200, 32'd0);
        for (int c = 0; c < 80 && order.size() < 4; c++) begin
            @(posedge clk); @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (change[p]) begin
                    change[p] = 1'b0;
                    drive(p, 1'b1, 1'b0, 32'(256 * (p + 1) + 4 * cidx[p]), 32'd0);
                end
            end
            if (m0_ack && m1_ack) overlap++;
            if (m0_ack || m1_ack) begin
                p_ack = int'(m1_ack);
                order.push_back(p_ack);
                check($sformatf("contend_rdata%0d", order.size()),
                      (p_ack == 0) ? m0_rdata : m1_rdata,
                      init_word(64 * (p_ack + 1) + cidx[p_ack]));
                $display("contention ack %0d: port %0d", order.size(), p_ack);
                cidx[p_ack]++;
                change[p_ack] = 1'b1;
            end
        end
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        check("contend_count", 96'(order.size()), 96'd4);
        if (order.size() == 4)
            check("contend_order", {32'(order[0]), 32'(order[1]), 32'(order[2])} ^ 96'(order[3]),
                  {32'd0, 32'd1, 32'd0} ^ 96'd1);
        check("contend_overlap", 96'(overlap), 96'd0);
        repeat (RW + 3) @(negedge clk);

        // ---------------- Back-to-back reads on port 0 --------------------
        nacks = 0; cyc = 0;
        drive(0, 1'b1, 1'b0, 32'h20, 32'd0);
        for (int c = 0; c < 60 && nacks < 3; c++) begin
            @(posedge clk); @(negedge clk);
            cyc++;
            if (m0_ack) begin
                ack_at[nacks] = cyc;
                nacks++;
                check($sformatf("b2b_rdata%0d", nacks), m0_rdata, init_word(8));
            end
        end
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        check("b2b_count", 96'(nacks), 96'd3);
        check("b2b_spacing", {32'(ack_at[1] - ack_at[0]), 32'(ack_at[2] - ack_at[1])},
              {32'(RW + 2), 32'(RW + 2)});
        $display("back-to-back: acks at %0d %0d %0d", ack_at[0], ack_at[1], ack_at[2]);
        repeat (RW + 3) @(negedge clk);

        // ---------------- Random traffic against a transaction model ------
        do_reset();
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        exp_rd[0] = 32'd0; exp_rd[1] = 32'd0;
        a_valid = 1'b0; mlast = 1'b1; free_edge = 0; e = 0; n_racks = 0;
        agent_busy[0] = 1'b0; agent_busy[1] = 1'b0; acked[0] = 1'b0; acked[1] = 1'b0;
        for (int cycn = 0; cycn < 2500; cycn++) begin
            @(posedge clk);
            e++;
            // The server is free once the previous access's ACK and IDLE
            // cycles have passed; then the lone requester, or the one not
            // served last, takes the next slot.
            if (!a_valid && e >= free_edge && (m0_req || m1_req)) begin
                pick    = (m0_req && m1_req) ? !mlast : m1_req;
                a_valid = 1'b1;
                a_port  = int'(pick);
                a_we    = pick ? m1_we : m0_we;
                a_addr  = pick ? m1_addr : m0_addr;
                a_wdata = pick ? m1_wdata : m0_wdata;
                a_start = e;
                a_lat   = a_we ? 1 : RW;
                mlast   = pick;
            end
            @(negedge clk);
            exp_stat = 96'd0;
            if (a_valid) begin
                if (e < a_start + a_lat) begin
                    exp_stat = {28'd0, !a_we, a_we, 2'b00, a_addr, a_wdata};
                end else if (e == a_start + a_lat) begin
                    exp_stat = {28'd0, 2'b00, a_port == 0, a_port == 1, 64'd0};
                    if (a_we) ref_mem[a_addr[9:2]] = a_wdata;
                    else      exp_rd[a_port] = ref_mem[a_addr[9:2]];
                    $display("rand ack %0d: port %0d we %0d addr %h", n_racks, a_port, a_we, a_addr);
                    n_racks++;
                    a_valid   = 1'b0;
                    free_edge = e + 2;
                end
            end
            check($sformatf("rand_status_e%0d", e), status(), exp_stat);
            check($sformatf("rand_rdata_e%0d", e), {m0_rdata, m1_rdata}, {exp_rd[0], exp_rd[1]});
            for (int p = 0; p < 2; p++) begin
                ackp = (p == 0) ? m0_ack : m1_ack;
                if (acked[p]) begin
                    acked[p] = 1'b0;
                    if ($urandom_range(0, 1) == 1) new_op(p);
                    else begin
                        drive(p, 1'b0, 1'b0, 32'd0, 32'd0);
                        agent_busy[p] = 1'b0;
                    end
                end else if (ackp) begin
                    acked[p] = 1'b1;
                end else if (!agent_busy[p] && $urandom_range(0, 2) == 0) begin
                    new_op(p);
                end
            end
        end
        check("rand_progress", 96'(n_racks >= 100), 96'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
